// File: rtl/exu_wbck_if.sv
// Write-back stage bus: ALU and LSU result handshakes, register-file write port and halt flag.
// master = producers/register-file side, slave = the exu_wbck stage.
`ifndef XLEN
`define XLEN 32
`endif

interface exu_wbck_if;
  logic              alu_wbck_i_valid;
  logic              alu_wbck_i_ready;
  logic [`XLEN-1:0]  alu_wbck_i_wdat;
  logic [4:0]        alu_wbck_i_rdidx;
  logic              alu_wbck_i_ebreak;

  logic              lsu_wbck_i_valid;
  logic              lsu_wbck_i_ready;
  logic [`XLEN-1:0]  lsu_wbck_i_wdat;
  logic [4:0]        lsu_wbck_i_rdidx;

  logic              rf_wbck_o_valid;
  logic              rf_wbck_o_ready;
  logic [`XLEN-1:0]  rf_wbck_o_wdat;
  logic [4:0]        rf_wbck_o_rdidx;

  logic              wbck_o_halted;

  modport master (
    output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, alu_wbck_i_ebreak,
    input  alu_wbck_i_ready,
    output lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
    input  lsu_wbck_i_ready,
    input  rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx,
    output rf_wbck_o_ready,
    input  wbck_o_halted
  );

  modport slave (
    input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx, alu_wbck_i_ebreak,
    output alu_wbck_i_ready,
    input  lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
    output lsu_wbck_i_ready,
    output rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx,
    input  rf_wbck_o_ready,
    output wbck_o_halted
  );
endinterface

// File: rtl/exu_wbck.sv
// EXU write-back: one-entry buffer fed by LSU (priority) and ALU, sticky halt on committed ebreak.
// Optional LSU source enabled by defining EXU_WBCK_LSU_EN; otherwise the ALU is the only source.
//
// Handshake: a transfer happens on any channel when valid and ready are both 1 at a rising
// clk edge; a producer holds valid and payload stable until it sees ready, and ready never
// depends on the same channel's payload.
`ifndef XLEN
`define XLEN 32
`endif

module exu_wbck (
  input  logic        clk,
  input  logic        rst,
  exu_wbck_if.slave   bus,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [`XLEN-1:0]  wdat_q, wdat_d;
  logic [4:0]        rdidx_q, rdidx_d;
  logic              ebreak_q, ebreak_d;
  logic              valid_q, halted_q;

  logic cap, lsu_req, lsu_take, alu_take, take;

`ifdef EXU_WBCK_LSU_EN
  assign lsu_req = bus.lsu_wbck_i_valid;
  assign bus.lsu_wbck_i_ready = cap;
`else
  logic unused_lsu;
  assign unused_lsu = ^{bus.lsu_wbck_i_valid, bus.lsu_wbck_i_wdat, bus.lsu_wbck_i_rdidx};
  assign lsu_req = 1'b0;
  assign bus.lsu_wbck_i_ready = 1'b0;
`endif

  assign bus.alu_wbck_i_ready = cap & ~lsu_req;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      wdat_q   <= '0;
      rdidx_q  <= '0;
      ebreak_q <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdat_q   <= wdat_d;
      rdidx_q  <= rdidx_d;
      ebreak_q <= ebreak_d;
      valid_q  <= (state_d == ST_FULL);
      halted_q <= (state_d == ST_HALT);
    end
  end

  // Next-state logic. A buffered ebreak blocks capture, so take is 0 on the FULL->HALT path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (take) state_d = ST_FULL;
      ST_FULL: begin
        if (bus.rf_wbck_o_ready) begin
          if (ebreak_q)   state_d = ST_HALT;
          else if (!take) state_d = ST_EMPTY;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output/datapath logic: capture enable, arbitration and the buffer's next contents.
  always_comb begin
    cap = 1'b0;
    if (!rst) begin
      cap = (state_q == ST_EMPTY) |
            ((state_q == ST_FULL) & bus.rf_wbck_o_ready & ~ebreak_q);
    end
    lsu_take = cap & lsu_req;
    alu_take = cap & ~lsu_req & bus.alu_wbck_i_valid;
    take     = lsu_take | alu_take;

    wdat_d   = wdat_q;
    rdidx_d  = rdidx_q;
    ebreak_d = ebreak_q;
    if (lsu_take) begin
      wdat_d   = bus.lsu_wbck_i_wdat;
      rdidx_d  = bus.lsu_wbck_i_rdidx;
      ebreak_d = 1'b0;
    end else if (alu_take) begin
      wdat_d   = bus.alu_wbck_i_wdat;
      rdidx_d  = bus.alu_wbck_i_rdidx;
      ebreak_d = bus.alu_wbck_i_ebreak;
    end
  end

  assign bus.rf_wbck_o_valid = valid_q;
  assign bus.rf_wbck_o_wdat  = wdat_q;
  assign bus.rf_wbck_o_rdidx = rdidx_q;
  assign bus.wbck_o_halted   = halted_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_exu_wbck.sv
// Bench for exu_wbck: directed scenarios plus randomized traffic against a queue-based model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_exu_wbck;
  localparam int W = `XLEN;

  typedef struct {
    logic [W-1:0] wdat;
    logic [4:0]   rdidx;
    bit           ebreak;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  exu_wbck_if bus ();

  exu_wbck dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  entry_t       mq[$];
  bit           m_halted;
  logic [W-1:0] exp_q[$];
  bit           alu_acc, lsu_acc;

`ifdef EXU_WBCK_LSU_EN
  localparam bit LSU_EN = 1'b1;
`else
  localparam bit LSU_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.alu_wbck_i_valid  = 1'b0;
    bus.alu_wbck_i_wdat   = '0;
    bus.alu_wbck_i_rdidx  = '0;
    bus.alu_wbck_i_ebreak = 1'b0;
    bus.lsu_wbck_i_valid  = 1'b0;
    bus.lsu_wbck_i_wdat   = '0;
    bus.lsu_wbck_i_rdidx  = '0;
    bus.rf_wbck_o_ready   = 1'b1;
  endtask

  task automatic set_alu(input bit v, input logic [W-1:0] d, input logic [4:0] r, input bit eb);
    bus.alu_wbck_i_valid  = v;
    bus.alu_wbck_i_wdat   = d;
    bus.alu_wbck_i_rdidx  = r;
    bus.alu_wbck_i_ebreak = eb;
  endtask

  task automatic set_lsu(input bit v, input logic [W-1:0] d, input logic [4:0] r);
    bus.lsu_wbck_i_valid = v;
    bus.lsu_wbck_i_wdat  = d;
    bus.lsu_wbck_i_rdidx = r;
  endtask

  // One clock: check readies mid-cycle, advance the model, check registered outputs after the edge.
  task automatic step();
    bit     room, e_lr, e_ar;
    entry_t e, n;
    @(negedge clk);
    room = !rst && !m_halted &&
           (mq.size() == 0 || (bus.rf_wbck_o_ready && !mq[0].ebreak));
    e_lr = LSU_EN && room;
    e_ar = room && !(LSU_EN && bus.lsu_wbck_i_valid);
    check("lsu_ready", bus.lsu_wbck_i_ready, e_lr);
    check("alu_ready", bus.alu_wbck_i_ready, e_ar);
    lsu_acc = e_lr && bus.lsu_wbck_i_valid;
    alu_acc = e_ar && bus.alu_wbck_i_valid;

    // Scoreboard: every register-file write must be the oldest accepted result.
    if (!rst && bus.rf_wbck_o_valid && bus.rf_wbck_o_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 1, 0);
      else check("sb_write_order", bus.rf_wbck_o_wdat, exp_q.pop_front());
    end

    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_halted = 1'b0;
    end else begin
      if (mq.size() != 0 && bus.rf_wbck_o_ready) begin
        e = mq.pop_front();
        if (e.ebreak) m_halted = 1'b1;
      end
      if (lsu_acc) begin
        n.wdat = bus.lsu_wbck_i_wdat; n.rdidx = bus.lsu_wbck_i_rdidx; n.ebreak = 1'b0;
        mq.push_back(n);
        exp_q.push_back(n.wdat);
      end else if (alu_acc) begin
        n.wdat = bus.alu_wbck_i_wdat; n.rdidx = bus.alu_wbck_i_rdidx; n.ebreak = bus.alu_wbck_i_ebreak;
        mq.push_back(n);
        exp_q.push_back(n.wdat);
      end
    end

    @(posedge clk);
    #1;
    check("rf_valid", bus.rf_wbck_o_valid, mq.size() != 0);
    check("halted", bus.wbck_o_halted, m_halted);
    if (mq.size() != 0) begin
      check("rf_wdat", bus.rf_wbck_o_wdat, mq[0].wdat);
      check("rf_rdidx", bus.rf_wbck_o_rdidx, mq[0].rdidx);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit           alu_pend, lsu_pend, x3_seen;
    logic [W-1:0] d;
    rst = 1'b1;
    idle_inputs();
    m_halted = 1'b0;

    // Reset state.
    do_reset(2);
    check("reset_valid", bus.rf_wbck_o_valid, 0);
    check("reset_wdat", bus.rf_wbck_o_wdat, 0);
    check("reset_rdidx", bus.rf_wbck_o_rdidx, 0);
    check("reset_halted", bus.wbck_o_halted, 0);

    // Single ALU write.
    set_alu(1, 'h1234, 5, 0);
    step();
    check("single_accepted", alu_acc, 1);
    set_alu(0, 0, 0, 0);
    check("single_wdat", bus.rf_wbck_o_wdat, 'h1234);
    check("single_rdidx", bus.rf_wbck_o_rdidx, 5);
    step();
    check("single_empty_after", bus.rf_wbck_o_valid, 0);

    // Four back-to-back results, no bubble.
    for (int i = 0; i < 4; i++) begin
      set_alu(1, 'h100 + i, 5'(10 + i), 0);
      step();
      check("stream_accept", alu_acc, 1);
    end
    set_alu(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step();

    // Register-file stall with a pending ALU result.
    set_alu(1, 'h55, 1, 0);
    step();
    bus.rf_wbck_o_ready = 1'b0;
    set_alu(1, 'h66, 2, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_accept", alu_acc, 0);
    end
    bus.rf_wbck_o_ready = 1'b1;
    step();
    check("stall_release_accept", alu_acc, 1);
    check("stall_next_captured", bus.rf_wbck_o_wdat, 'h66);
    set_alu(0, 0, 0, 0);
    step();

    // LSU and ALU contend; LSU wins, ALU holds.
    set_lsu(1, 'hAA, 7);
    set_alu(1, 'hBB, 8, 0);
    step();
    check("contend_lsu_acc", lsu_acc, LSU_EN);
    set_lsu(0, 0, 0);
    if (!alu_acc) step();
    set_alu(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step();

    // ebreak then a younger result that must stay blocked until reset.
    set_alu(1, 'h0, 0, 1);
    step();
    set_alu(1, 'h99, 3, 0);
    x3_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (alu_acc) x3_seen = 1'b1;
    end
    check("halt_set", bus.wbck_o_halted, 1);
    check("halt_blocks_x3", x3_seen, 0);
    do_reset(1);
    step();
    check("x3_after_reset", alu_acc, 1);
    set_alu(0, 0, 0, 0);
    step();

    // Reset while FULL loses the entry.
    bus.rf_wbck_o_ready = 1'b0;
    set_alu(1, 'h77, 9, 0);
    step();
    set_alu(0, 0, 0, 0);
    step();
    do_reset(1);
    check("reset_full_lost", bus.rf_wbck_o_valid, 0);
    bus.rf_wbck_o_ready = 1'b1;
    step();

    // Randomized traffic: producers hold their request until accepted.
    alu_pend = 1'b0;
    lsu_pend = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!alu_pend && $urandom_range(0, 2) != 0) begin
        d = W'($urandom);
        set_alu(1, d, 5'($urandom_range(0, 31)), $urandom_range(0, 40) == 0);
        alu_pend = 1'b1;
      end
      if (!lsu_pend && $urandom_range(0, 2) == 0) begin
        d = W'($urandom);
        set_lsu(1, d, 5'($urandom_range(0, 31)));
        lsu_pend = 1'b1;
      end
      bus.rf_wbck_o_ready = ($urandom_range(0, 3) != 0);
      rst = (m_halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 150) == 0);
      step();
      if (alu_acc || rst) begin alu_pend = 1'b0; set_alu(0, 0, 0, 0); end
      if (lsu_acc || rst) begin lsu_pend = 1'b0; set_lsu(0, 0, 0); end
      // Without the LSU source its requests are never taken; retire them randomly.
      if (!LSU_EN && lsu_pend && $urandom_range(0, 3) == 0) begin
        lsu_pend = 1'b0;
        set_lsu(0, 0, 0);
      end
    end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    check("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exu_wbck.md
# exu_wbck

Write-back stage of the EXU: the consumer end of the ALU result handshake (`alu_o_valid`/`alu_o_ready`/`alu_o_wbck_wdat`/`alu_o_cmt_ebreak`). It arbitrates ALU and LSU results into a one-entry registered write-back buffer and drives the register-file write port. It also turns a committed `ebreak` into a sticky halt that stops all further write-backs.

## Interface
- No parameters; data width is `XLEN` from `defines.v`, register index width is fixed at 5.
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- alu_wbck_i_valid  in  1  ALU result valid (driven by ALU `alu_o_valid`)
- alu_wbck_i_ready  out  1  ALU result accepted (to ALU `alu_o_ready`)
- alu_wbck_i_wdat  in  XLEN  ALU result data
- alu_wbck_i_rdidx  in  5  destination register
- alu_wbck_i_ebreak  in  1  instruction is `ebreak`
- lsu_wbck_i_valid  in  1  load result valid
- lsu_wbck_i_ready  out  1  load result accepted
- lsu_wbck_i_wdat  in  XLEN  load data
- lsu_wbck_i_rdidx  in  5  destination register
- rf_wbck_o_valid  out  1  register-file write request
- rf_wbck_o_ready  in  1  register file accepts the write
- rf_wbck_o_wdat  out  XLEN  write data
- rf_wbck_o_rdidx  out  5  write index
- wbck_o_halted  out  1  sticky: `ebreak` committed

## Operation
- States: EMPTY (no entry), FULL (entry held, `rf_wbck_o_valid`=1), HALT (terminal until `rst`).
- Source selection: LSU has fixed priority over ALU when both are valid in the same cycle; the losing source sees ready=0 and must hold its request.
- Capture enable: `cap = (state==EMPTY) | (state==FULL & rf_wbck_o_ready & ~buf_ebreak)`. `lsu_wbck_i_ready = cap`; `alu_wbck_i_ready = cap & ~lsu_wbck_i_valid`. Both readies are 0 in HALT and while reset is asserted.
- Handshake on each input: a transfer occurs when valid & ready are both 1 in the same cycle; readies do not depend on the same source's data.
- Captured entry: {wdat, rdidx, ebreak}; LSU entries capture ebreak=0.
- Transitions: EMPTY --transfer--> FULL. FULL --`rf_wbck_o_ready` & new transfer--> FULL (back-to-back). FULL --`rf_wbck_o_ready` & no transfer--> EMPTY. FULL --`rf_wbck_o_ready` & buf_ebreak--> HALT. FULL without `rf_wbck_o_ready` stays FULL; outputs hold stable.
- An `ebreak` entry is presented like any other (rdidx as given, normally x0); nothing is accepted behind it (cap=0 while it is buffered).
- HALT: `wbck_o_halted`=1, `rf_wbck_o_valid`=0, all readies 0; further valids are ignored.
- rdidx 0 entries are presented normally; the register file discards them.

## Timing
- Reset (sync, `rst`=1 at a clk edge): state EMPTY, `rf_wbck_o_valid`=0, `rf_wbck_o_wdat`=0, `rf_wbck_o_rdidx`=0, `wbck_o_halted`=0; readies evaluate to 0 during reset. Reset mid-operation discards the buffered entry and clears HALT.
- Latency: input transfer at edge N → `rf_wbck_o_valid`=1 with the data from cycle N+1.
- Throughput: one write-back per cycle while `rf_wbck_o_ready`=1 (combinational ready pass-through, no bubble).
- `wbck_o_halted` rises in the cycle after the `ebreak` entry's `rf_wbck_o_ready` handshake.
- All outputs are registered except the readies, which are combinational from state, `rf_wbck_o_ready`, and `lsu_wbck_i_valid`.

## Configuration
- `EXU_WBCK_LSU_EN` defined: the LSU port and priority arbitration are present as described.
- Not defined: LSU input is unused; `lsu_wbck_i_ready` is tied to 0; `alu_wbck_i_ready = cap`; the ALU is the sole source; all other behaviour is unchanged.

## Test plan
- Reset then single ALU write {wdat=0x1234, rdidx=5} → `alu_wbck_i_ready`=1; the next cycle `rf_wbck_o_valid`=1, wdat=0x1234, rdidx=5; EMPTY again after the ready handshake.
- ALU streams 4 results with `rf_wbck_o_ready`=1 → 4 consecutive write cycles with no bubble and in order.
- `rf_wbck_o_ready`=0 for 3 cycles with the buffer FULL and the ALU valid → `alu_wbck_i_ready`=0 and outputs stable; on release, the held entry is written and the next entry is captured in the same cycle.
- LSU {0xAA, x7} and ALU {0xBB, x8} valid in the same cycle → x7 written first, then x8 one cycle later; ALU data held unchanged while stalled (with `EXU_WBCK_LSU_EN`).
- ALU `ebreak` (rdidx 0) followed by ALU valid {0x99, x3} → `ebreak` entry presented, then `wbck_o_halted`=1; x3 is never accepted; `rst` pulse clears the halt and x3 is then accepted.
- `rst` asserted while FULL → next cycle `rf_wbck_o_valid`=0 and the entry is lost.
